prod_dump_acc: RTL and testbench
================================

// Module: prod_dump_acc
// PURPOSE
//  Integrate-and-dump stage directly downstream of the 16x16 err_mult multiplier.
//  Consumes its truncated signed product (q = product[31:16]) and sums ACC_LEN samples.
//  Then applies a rounded right shift, saturates to 16 bits and presents one result per window.
//  Output uses a valid/ready handshake toward the error/loop-filter stage.
// PARAMETERS
//  DW        16  sample and result width, signed two's complement
//  ACC_LEN   16  samples per dump window; power of 2, 2..256
//  OUT_SHIFT 2   right shift applied to the window sum; 0..$clog2(ACC_LEN)
//  (local) AW = DW + $clog2(ACC_LEN) + 1  accumulator width, incl. rounding headroom
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  clr       in   1   sync clear of accumulator and sample count
//  in_valid  in   1   in_data valid
//  in_ready  out  1   stage accepts a sample this cycle
//  in_data   in   DW  signed sample (multiplier q)
//  out_valid out  1   out_data holds a result
//  out_ready in   1   consumer takes out_data this cycle
//  out_data  out  DW  rounded, saturated window result
//  sat_flag  out  1   only with ACC_SAT_FLAG_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset=0): acc=0, cnt=0, state=ACCUM, out_valid=0, out_data=0, sat_flag=0.
//    Takes effect immediately, including mid-window and in FULL.
//  - Accept: in_valid & in_ready. Transfer: out_valid & out_ready.
//    slot_free = !out_valid | out_ready.
//  - in_ready = (state==ACCUM); purely combinational from state.
//  - State ACCUM, accept with cnt<ACC_LEN-1: acc += sext(in_data); cnt++.
//  - State ACCUM, accept with cnt==ACC_LEN-1: sum = acc + sext(in_data).
//    - slot_free: out_data <= sat(rnd(sum)), out_valid <= 1, acc <= 0, cnt <= 0.
//    - else: acc <= sum, state -> FULL.
//  - State FULL: in_ready=0.
//    - When slot_free: load out_data from acc, out_valid <= 1, acc <= 0, cnt <= 0, state -> ACCUM.
//  - Latency: result is visible on out_data the cycle after the last accept (or the cycle after the slot frees).
//  - A transfer with no new load clears out_valid. A transfer with a load in the same cycle keeps out_valid=1.
//  - out_data is stable while out_valid=1 and out_ready=0.
//  - rnd(s): OUT_SHIFT==0 gives s.
//    Otherwise (s + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, arithmetic (round half up).
//  - sat(x): clamp to [-2^(DW-1), 2^(DW-1)-1], i.e. 0x8000..0x7FFF for DW=16.
//  - acc never wraps: AW covers ACC_LEN full-scale samples plus the rounding add.
//  - clr (ACCUM or FULL): acc=0, cnt=0, state=ACCUM. Output register and out_valid are untouched.
//    clr with a simultaneous accept: clr wins and the sample is dropped.
//  - in_valid=0 gaps are allowed anywhere; the window counts accepted samples only.
// CONFIGURATION
//  ACC_SAT_FLAG_EN defined:
//    - sat_flag port exists.
//    - Loaded with out_data; 1 if the clamp changed the value.
//    - Same valid/hold rules as out_data; reset 0.
//  ACC_SAT_FLAG_EN undefined: no sat_flag port; saturation is silent. All other behaviour is identical.
// TESTING  (DW=16, ACC_LEN=16, OUT_SHIFT=2 unless noted)
//  1. Reset held, random inputs:
//     out_valid=0, out_data=0 while reset=0; in_ready=1 after release.
//  2. 16 x 0x0100, out_ready=1:
//     out_valid=1 with out_data=0x0400 one cycle after the 16th accept.
//  3. 16 x 0x7FFF, then 16 x 0x8000:
//     results 0x7FFF and 0x8000; sat_flag=1 both times if ACC_SAT_FLAG_EN.
//  4. out_ready=0, 32 x 0x0001:
//     first result 0x0004 holds; in_ready=0 after the 32nd accept.
//     Raise out_ready: next cycle out_data=0x0004 (second window), out_valid stays 1, in_ready=1.
//  5. 5 samples, clr, then 16 x 0x0004:
//     single result 0x0010; a sample coincident with clr is not counted.
//  6. Reset asserted in FULL:
//     out_valid=0 and out_data=0 immediately; the next 16 x 0x0100 yields 0x0400.

Source files
------------

// File: rtl/prod_dump_acc.sv
// prod_dump_acc: integrate-and-dump of ACC_LEN signed samples with rounded shift, 16-bit saturation and valid/ready output
// Ports: clk, reset (async active-low), clr (sync window clear),
//        in_valid/in_ready/in_data (sample stream), out_valid/out_ready/out_data (result stream),
//        sat_flag (only when ACC_SAT_FLAG_EN is defined: result was clamped).
// Optional feature macro: ACC_SAT_FLAG_EN.
module prod_dump_acc #(
  parameter int DW        = 16,
  parameter int ACC_LEN   = 16,
  parameter int OUT_SHIFT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef ACC_SAT_FLAG_EN
  ,output logic         sat_flag
`endif
);
  localparam int CW = $clog2(ACC_LEN);
  localparam int AW = DW + CW + 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  localparam logic signed [AW-1:0] RND = AW'((1 << OUT_SHIFT) >> 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  typedef enum logic {ACCUM, FULL} state_t;
  state_t state_q;
  logic signed [AW-1:0] acc_q, sum_d, src_d, rnd_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] out_data_q, res_d;
  logic out_valid_q, slot_free, hi_d, lo_d;
  assign in_ready  = state_q == ACCUM;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign slot_free = !out_valid_q || out_ready;
  assign sum_d = acc_q + {{(AW-DW){in_data[DW-1]}}, in_data};
  // In FULL the finished window sum already sits in acc_q.
  assign src_d = state_q == FULL ? acc_q : sum_d;
  assign rnd_d = (src_d + RND) >>> OUT_SHIFT;
  assign hi_d  = rnd_d > SMAX;
  assign lo_d  = rnd_d < SMIN;
  assign res_d = hi_d ? SMAX[DW-1:0] : lo_d ? SMIN[DW-1:0] : rnd_d[DW-1:0];
`ifdef ACC_SAT_FLAG_EN
  logic sat_q;
  assign sat_flag = sat_q;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ACC_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      // A load later in this block overrides the transfer clear.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (clr) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= ACCUM;
      end else if (state_q == FULL) begin
        if (slot_free) begin
          out_data_q  <= res_d;
          out_valid_q <= 1'b1;
`ifdef ACC_SAT_FLAG_EN
          sat_q       <= hi_d || lo_d;
`endif
          acc_q       <= '0;
          cnt_q       <= '0;
          state_q     <= ACCUM;
        end
      end else if (in_valid) begin
        if (cnt_q != LAST) begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + 1'b1;
        end else if (slot_free) begin
          out_data_q  <= res_d;
          out_valid_q <= 1'b1;
`ifdef ACC_SAT_FLAG_EN
          sat_q       <= hi_d || lo_d;
`endif
          acc_q       <= '0;
          cnt_q       <= '0;
        end else begin
          acc_q   <= sum_d;
          state_q <= FULL;
        end
      end
    end
  end
endmodule

// File: tb/tb_prod_dump_acc.sv
// tb_prod_dump_acc: directed and random checks of prod_dump_acc against a window-sum reference model
module tb_prod_dump_acc;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int SH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
`ifdef ACC_SAT_FLAG_EN
  logic sat_flag;
`endif
  always #5 clk = ~clk;
  prod_dump_acc #(.DW(DW), .ACC_LEN(N), .OUT_SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ACC_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );
  int vectors = 0;
  int miscompares = 0;
  longint m_sum;
  int m_cnt;
  bit m_pend, m_valid, m_flag;
  logic [DW-1:0] m_data;
  // Round half up then divide by 2^SH, using floor division on plain integers.
  function automatic longint rnd_div(input longint s);
    longint d, t, q;
    d = longint'(1) << SH;
    t = s + d / 2;
    q = t / d;
    if (t % d != 0 && t < 0) q = q - 1;
    return q;
  endfunction
  task automatic m_reset();
    m_sum = 0; m_cnt = 0; m_pend = 0; m_valid = 0; m_flag = 0; m_data = '0;
  endtask
  task automatic m_load(input longint s);
    longint q, c;
    q = rnd_div(s);
    c = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
    m_data = c[DW-1:0];
    m_flag = q != c;
    m_valid = 1;
  endtask
  task automatic m_step();
    bit free;
    free = !m_valid || out_ready;
    if (m_valid && out_ready) m_valid = 0;
    if (clr) begin
      m_sum = 0; m_cnt = 0; m_pend = 0;
    end else if (m_pend) begin
      if (free) begin m_load(m_sum); m_sum = 0; m_cnt = 0; m_pend = 0; end
    end else if (in_valid) begin
      m_sum = m_sum + longint'($signed(in_data));
      m_cnt = m_cnt + 1;
      if (m_cnt == N) begin
        if (free) begin m_load(m_sum); m_sum = 0; m_cnt = 0; end
        else m_pend = 1;
      end
    end
  endtask
  task automatic check(input string tag);
    vectors++;
    assert (out_valid === m_valid) else begin
      miscompares++; $error("FAIL %s out_valid observed %0b expected %0b", tag, out_valid, m_valid);
    end
    assert (out_data === m_data) else begin
      miscompares++; $error("FAIL %s out_data observed %h expected %h", tag, out_data, m_data);
    end
    assert (in_ready === !m_pend) else begin
      miscompares++; $error("FAIL %s in_ready observed %0b expected %0b", tag, in_ready, !m_pend);
    end
`ifdef ACC_SAT_FLAG_EN
    assert (sat_flag === m_flag) else begin
      miscompares++; $error("FAIL %s sat_flag observed %0b expected %0b", tag, sat_flag, m_flag);
    end
`endif
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
    assert (out_valid === v && out_data === d && in_ready === r) else begin
      miscompares++;
      $error("FAIL %s observed v=%0b d=%h rdy=%0b expected v=%0b d=%h rdy=%0b", tag, out_valid, out_data, in_ready, v, d, r);
    end
  endtask
  task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    in_valid = v; in_data = d; out_ready = r; clr = c;
    @(posedge clk);
    if (reset) m_step();
    @(negedge clk);
    check(tag);
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 m_reset();
    check(tag);
    for (int i = 0; i < 3; i++) cyc(tag, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    reset = 1'b1;
  endtask
  initial begin
    m_reset();
    // 1: reset held with random inputs
    for (int i = 0; i < 4; i++) cyc("reset_hold", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    reset = 1'b1;
    cyc("release", 1'b0, '0, 1'b1, 1'b0);
    expect_out("release_ready", 1'b0, 16'h0000, 1'b1);
    // 2: basic window
    for (int i = 0; i < N; i++) cyc("win_0100", 1'b1, 16'h0100, 1'b1, 1'b0);
    expect_out("res_0400", 1'b1, 16'h0400, 1'b1);
    // 3: positive and negative saturation
    for (int i = 0; i < N; i++) cyc("win_7fff", 1'b1, 16'h7FFF, 1'b1, 1'b0);
    expect_out("sat_hi", 1'b1, 16'h7FFF, 1'b1);
    for (int i = 0; i < N; i++) cyc("win_8000", 1'b1, 16'h8000, 1'b1, 1'b0);
    expect_out("sat_lo", 1'b1, 16'h8000, 1'b1);
    cyc("drain3", 1'b0, '0, 1'b1, 1'b0);
    // 4: backpressure into FULL, then release
    for (int i = 0; i < 2 * N; i++) cyc("bp_0001", 1'b1, 16'h0001, 1'b0, 1'b0);
    expect_out("bp_full", 1'b1, 16'h0004, 1'b0);
    cyc("bp_free", 1'b0, '0, 1'b1, 1'b0);
    expect_out("bp_reload", 1'b1, 16'h0004, 1'b1);
    cyc("drain4", 1'b0, '0, 1'b1, 1'b0);
    // 5: clr mid-window, coincident sample dropped
    for (int i = 0; i < 5; i++) cyc("pre_clr", 1'b1, 16'h0033, 1'b1, 1'b0);
    cyc("clr", 1'b1, 16'h0777, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) cyc("win_0004", 1'b1, 16'h0004, 1'b1, 1'b0);
    expect_out("res_0010", 1'b1, 16'h0010, 1'b1);
    // 6: reset while FULL
    for (int i = 0; i < 2 * N; i++) cyc("fill", 1'b1, 16'h1234, 1'b0, 1'b0);
    expect_out("in_full", 1'b1, out_data, 1'b0);
    async_reset("rst_full");
    for (int i = 0; i < N; i++) cyc("post_rst", 1'b1, 16'h0100, 1'b1, 1'b0);
    expect_out("post_rst_0400", 1'b1, 16'h0400, 1'b1);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [DW-1:0] d;
      int k;
      k = $urandom_range(0, 9);
      d = k == 0 ? 16'h7FFF : k == 1 ? 16'h8000 : 16'($urandom);
      cyc("rand", $urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
